// File: rtl/pad_supply_seq.sv
// N-domain IO-ring supply model: rails ramp up in index order, drop in reverse, brown-out latches a fault.
// All outputs registered; stage timing set by RAMP_CYCLES; no backpressure, PWR_REQ is a plain level.
module pad_supply_seq #(
  parameter int N_DOMAINS   = 2,
  parameter int RAMP_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 PWR_REQ,
  input  logic                 BROWNOUT,
  input  logic                 FAULT_CLR,
  output logic [N_DOMAINS-1:0] VDD_RAIL,
  output logic [N_DOMAINS-1:0] PGOOD,
  output logic                 ALL_GOOD,
  output logic                 BUSY,
  output logic                 FAULT
);

  localparam int TW = $clog2(RAMP_CYCLES + 1);
  localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(RAMP_CYCLES - 1);
  localparam logic [IW-1:0] LAST   = IW'(N_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_RAMP_UP,
    S_ON,
    S_RAMP_DOWN,
    S_FAULT
  } state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt, idx_inc, idx_dec;
  logic [TW-1:0]          timer, timer_nxt;
  logic [N_DOMAINS-1:0]   vdd_nxt, pg_nxt;
  logic                   all_good_nxt, busy_nxt, fault_nxt;
  logic                   expired;
  logic [1:0]             rst_sync;
  logic                   rst_n;

  // Reset asserts immediately, releases two edges later so no flop sees a partial release.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign idx_inc = idx + IW'(1);
  assign idx_dec = idx - IW'(1);
  assign expired = (timer == '0);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timer_nxt = timer;
    vdd_nxt   = VDD_RAIL;
    pg_nxt    = PGOOD;
    case (state)
      S_OFF: begin
        if (PWR_REQ) begin
          state_nxt  = S_RAMP_UP;
          idx_nxt    = '0;
          timer_nxt  = RELOAD;
          vdd_nxt[0] = 1'b1;
        end
      end
      S_RAMP_UP: begin
        // An abort unwinds from the current stage; its PGOOD has not risen yet.
        if (!PWR_REQ) begin
          state_nxt = S_RAMP_DOWN;
          timer_nxt = RELOAD;
        end else if (expired) begin
          pg_nxt[idx] = 1'b1;
          if (idx == LAST) begin
            state_nxt = S_ON;
          end else begin
            vdd_nxt[idx_inc] = 1'b1;
            idx_nxt          = idx_inc;
            timer_nxt        = RELOAD;
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      S_ON: begin
        if (!PWR_REQ) begin
          state_nxt    = S_RAMP_DOWN;
          idx_nxt      = LAST;
          timer_nxt    = RELOAD;
          pg_nxt[LAST] = 1'b0;
        end
      end
      S_RAMP_DOWN: begin
        if (expired) begin
          vdd_nxt[idx] = 1'b0;
          if (idx == '0) begin
            state_nxt = S_OFF;
          end else begin
            pg_nxt[idx_dec] = 1'b0;
            idx_nxt         = idx_dec;
            timer_nxt       = RELOAD;
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      S_FAULT: begin
        if (FAULT_CLR && !PWR_REQ) state_nxt = S_OFF;
      end
      default: state_nxt = S_OFF;
    endcase

    // Brown-out beats any request change or stage expiry in the same cycle.
    if (BROWNOUT && (state == S_RAMP_UP || state == S_ON || state == S_RAMP_DOWN)) begin
      state_nxt = S_FAULT;
      idx_nxt   = '0;
      timer_nxt = '0;
      vdd_nxt   = '0;
      pg_nxt    = '0;
    end

    all_good_nxt = (state_nxt == S_ON);
    busy_nxt     = (state_nxt == S_RAMP_UP) || (state_nxt == S_RAMP_DOWN);
    fault_nxt    = (state_nxt == S_FAULT);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_OFF;
      idx      <= '0;
      timer    <= '0;
      VDD_RAIL <= '0;
      PGOOD    <= '0;
      ALL_GOOD <= 1'b0;
      BUSY     <= 1'b0;
      FAULT    <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      timer    <= timer_nxt;
      VDD_RAIL <= vdd_nxt;
      PGOOD    <= pg_nxt;
      ALL_GOOD <= all_good_nxt;
      BUSY     <= busy_nxt;
      FAULT    <= fault_nxt;
    end
  end

  a_pg_needs_rail: assert property (@(posedge CLK) disable iff (!rst_n)
    (PGOOD & ~VDD_RAIL) == '0);
  a_rails_in_order: assert property (@(posedge CLK) disable iff (!rst_n)
    (VDD_RAIL & (VDD_RAIL + 1'b1)) == '0);
  a_status_exclusive: assert property (@(posedge CLK) disable iff (!rst_n)
    $onehot0({BUSY, FAULT, ALL_GOOD}));

endmodule

// File: tb/tb_pad_supply_seq.sv
// Drives four differently sized supply models from shared inputs and checks each against a rail-count model.
module tb_pad_supply_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req = 1'b0;
  logic bo = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  logic [1:0] v0, p0;
  logic [2:0] v1, p1;
  logic [0:0] v2, p2;
  logic [3:0] v3, p3;
  logic g0, b0, f0, g1, b1, f1, g2, b2, f2, g3, b3, f3;

  pad_supply_seq #(.N_DOMAINS(2), .RAMP_CYCLES(4)) u0 (
    .CLK(clk), .RESETn(rst_n), .PWR_REQ(req), .BROWNOUT(bo), .FAULT_CLR(clr),
    .VDD_RAIL(v0), .PGOOD(p0), .ALL_GOOD(g0), .BUSY(b0), .FAULT(f0));
  pad_supply_seq #(.N_DOMAINS(3), .RAMP_CYCLES(4)) u1 (
    .CLK(clk), .RESETn(rst_n), .PWR_REQ(req), .BROWNOUT(bo), .FAULT_CLR(clr),
    .VDD_RAIL(v1), .PGOOD(p1), .ALL_GOOD(g1), .BUSY(b1), .FAULT(f1));
  pad_supply_seq #(.N_DOMAINS(1), .RAMP_CYCLES(1)) u2 (
    .CLK(clk), .RESETn(rst_n), .PWR_REQ(req), .BROWNOUT(bo), .FAULT_CLR(clr),
    .VDD_RAIL(v2), .PGOOD(p2), .ALL_GOOD(g2), .BUSY(b2), .FAULT(f2));
  pad_supply_seq #(.N_DOMAINS(4), .RAMP_CYCLES(8)) u3 (
    .CLK(clk), .RESETn(rst_n), .PWR_REQ(req), .BROWNOUT(bo), .FAULT_CLR(clr),
    .VDD_RAIL(v3), .PGOOD(p3), .ALL_GOOD(g3), .BUSY(b3), .FAULT(f3));

  // Packed view: {vdd[7:0], pgood[7:0], all_good, busy, fault}
  logic [18:0] obs [4];
  assign obs[0] = {6'd0, v0, 6'd0, p0, g0, b0, f0};
  assign obs[1] = {5'd0, v1, 5'd0, p1, g1, b1, f1};
  assign obs[2] = {7'd0, v2, 7'd0, p2, g2, b2, f2};
  assign obs[3] = {4'd0, v3, 4'd0, p3, g3, b3, f3};

  // Model: how many rails are up, how many are good, ramp direction, cycles spent in the stage.
  int m_rails [4];
  int m_goods [4];
  int m_dir   [4];
  int m_age   [4];
  bit m_fault [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic int nn(int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int rr(int i);
    case (i)
      0: return 4;
      1: return 4;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [18:0] mk(logic [7:0] v, logic [7:0] p, logic g, logic b, logic f);
    return {v, p, g, b, f};
  endfunction

  function automatic logic [18:0] model_exp(int i);
    logic [7:0] v, p;
    v = 8'((1 << m_rails[i]) - 1);
    p = 8'((1 << m_goods[i]) - 1);
    return mk(v, p, (m_dir[i] == 0) && (m_rails[i] == nn(i)) && !m_fault[i],
              m_dir[i] != 0, m_fault[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_rails[i] = 0; m_goods[i] = 0; m_dir[i] = 0; m_age[i] = 0; m_fault[i] = 1'b0;
    end
  endtask

  task automatic model_step(int i, logic r, logic b, logic c);
    if (m_fault[i]) begin
      if (c && !r) m_fault[i] = 1'b0;
    end else if (m_dir[i] == 0 && m_rails[i] == 0) begin
      if (r) begin m_rails[i] = 1; m_dir[i] = 1; m_age[i] = 0; end
    end else if (b) begin
      m_rails[i] = 0; m_goods[i] = 0; m_dir[i] = 0; m_fault[i] = 1'b1;
    end else if (m_dir[i] == 0) begin
      if (!r) begin m_dir[i] = -1; m_goods[i] = nn(i) - 1; m_age[i] = 0; end
    end else if (m_dir[i] == 1) begin
      if (!r) begin
        m_dir[i] = -1; m_age[i] = 0;
      end else begin
        m_age[i]++;
        if (m_age[i] == rr(i)) begin
          m_age[i] = 0;
          m_goods[i]++;
          if (m_rails[i] < nn(i)) m_rails[i]++;
          else m_dir[i] = 0;
        end
      end
    end else begin
      m_age[i]++;
      if (m_age[i] == rr(i)) begin
        m_age[i] = 0;
        m_rails[i]--;
        m_goods[i] = (m_rails[i] > 0) ? m_rails[i] - 1 : 0;
        if (m_rails[i] == 0) m_dir[i] = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [18:0] o, logic [18:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cycle(logic r, logic b, logic c);
    req = r; bo = b; clr = c;
    @(posedge clk);
    if (rst_n) for (int i = 0; i < 4; i++) model_step(i, r, b, c);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("cyc%0d_u%0d", cyc, i), obs[i], model_exp(i));
    cyc++;
  endtask

  initial begin
    logic r;
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk("reset_u0", obs[0], 19'd0);
    chk("reset_u3", obs[3], 19'd0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Power-up; test-plan edge numbers count from the first edge that sees the request.
    for (int e = 1; e <= 40; e++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (e == 1) chk("pu_e1", obs[0], mk(8'h01, 8'h00, 1'b0, 1'b1, 1'b0));
      if (e == 2) chk("n1_r1_on", obs[2], mk(8'h01, 8'h01, 1'b1, 1'b0, 1'b0));
      if (e == 5) chk("pu_e5", obs[0], mk(8'h03, 8'h01, 1'b0, 1'b1, 1'b0));
      if (e == 9) chk("pu_e9", obs[0], mk(8'h03, 8'h03, 1'b1, 1'b0, 1'b0));
    end

    // Power-down from ON.
    for (int e = 1; e <= 35; e++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (e == 1) chk("pd_t1", obs[0], mk(8'h03, 8'h01, 1'b0, 1'b1, 1'b0));
      if (e == 5) chk("pd_t5", obs[0], mk(8'h01, 8'h00, 1'b0, 1'b1, 1'b0));
      if (e == 9) chk("pd_t9", obs[0], mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    end

    // Abort two cycles into stage 1 of the three-domain model.
    for (int e = 1; e <= 20; e++) begin
      cycle(logic'(e <= 6), 1'b0, 1'b0);
      if (e == 7)  chk("abort_enter", obs[1], mk(8'h03, 8'h01, 1'b0, 1'b1, 1'b0));
      if (e == 11) chk("abort_rail1", obs[1], mk(8'h01, 8'h00, 1'b0, 1'b1, 1'b0));
      if (e == 15) chk("abort_rail0", obs[1], mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    end

    // Request re-raised during ramp-down: finish to OFF, restart one cycle later.
    repeat (40) cycle(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 80; e++) begin
      cycle(logic'(e > 2), 1'b0, 1'b0);
      if (e == 9)  chk("toggle_off", obs[0], mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
      if (e == 10) chk("toggle_restart", obs[0], mk(8'h01, 8'h00, 1'b0, 1'b1, 1'b0));
    end

    // Brown-out in ON, then clear attempts.
    cycle(1'b1, 1'b1, 1'b0);
    chk("bo_fault", obs[0], mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
    cycle(1'b1, 1'b0, 1'b1);
    chk("bo_clr_req1", obs[3], mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
    cycle(1'b0, 1'b0, 1'b1);
    chk("bo_clr_req0", obs[0], 19'd0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("bo_in_off", obs[0], 19'd0);

    // Async reset between edges while the four-domain model is in stage 2.
    for (int e = 1; e <= 19; e++) cycle(1'b1, 1'b0, 1'b0);
    chk("stage2_u3", obs[3], mk(8'h07, 8'h03, 1'b0, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1 for (int i = 0; i < 4; i++) chk($sformatf("async_rst_u%0d", i), obs[i], 19'd0);
    model_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("restart_dom0", obs[3], mk(8'h01, 8'h00, 1'b0, 1'b1, 1'b0));

    // Randomised mix of request levels, brown-outs and clears.
    r = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) r = ~r;
      cycle(r, logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_supply_seq.md
Name: pad_supply_seq

Overview:
- Parametrised successor to the single always-on VDDIO pad model: a behavioural model of an N-domain IO-ring supply with sequenced rail ramp-up and ramp-down.
- Each rail has a power-good flag, and a brown-out fault path forces all rails off.
- Sits in the pad/IO-ring model layer. SoC-level benches use it to exercise power-on sequencing and pad-domain isolation logic, which a constant-1 supply pad cannot do.

Parameters:
- N_DOMAINS, 2, number of supply domains, legal 1..8; index 0 powers first and drops last.
- RAMP_CYCLES, 16, clock cycles per rail ramp stage, legal 1..65535.

Ports:
- CLK  input  1  model clock.
- RESETn  input  1  asynchronous active-low reset. One clock only; reset is asynchronous, active-low.
- PWR_REQ  input  1  level request: 1 = supplies up, 0 = supplies down.
- BROWNOUT  input  1  fault injection, sampled on CLK.
- FAULT_CLR  input  1  clears latched fault, sampled on CLK.
- VDD_RAIL  output  N_DOMAINS  rail level per domain (1 = supply present).
- PGOOD  output  N_DOMAINS  power-good per domain.
- ALL_GOOD  output  1  all PGOOD set and FSM in ON.
- BUSY  output  1  FSM in RAMP_UP or RAMP_DOWN.
- FAULT  output  1  FSM in FAULT.

Behaviour:
- All outputs registered.
- Reset (async assert, sync-released internally): state OFF, idx=0, timer=0, all outputs 0.
- Timer width is clog2(RAMP_CYCLES+1); idx width is clog2(N_DOMAINS), minimum 1.
- States: OFF, RAMP_UP, ON, RAMP_DOWN, FAULT.
- OFF:
  - PWR_REQ=1 sampled -> RAMP_UP, idx=0, VDD_RAIL[0]=1 at the next edge, timer loads RAMP_CYCLES-1.
- RAMP_UP stage k:
  - Timer decrements each cycle.
  - At expiry with k<N-1: PGOOD[k]=1, VDD_RAIL[k+1]=1 on the same edge, idx=k+1, timer reloads.
  - At expiry with k=N-1: PGOOD[k]=1, ALL_GOOD=1, state ON.
  - PGOOD[k] therefore rises exactly RAMP_CYCLES cycles after VDD_RAIL[k].
- ON:
  - PWR_REQ=0 sampled -> RAMP_DOWN, idx=N-1.
  - On that edge PGOOD[N-1]=0 and ALL_GOOD=0; timer loads RAMP_CYCLES-1.
- RAMP_DOWN stage k:
  - At expiry: VDD_RAIL[k]=0.
  - If k>0: PGOOD[k-1]=0 on the same edge, idx=k-1, timer reloads.
  - If k=0: state OFF.
- Abort during RAMP_UP (PWR_REQ=0 sampled at stage k):
  - Enter RAMP_DOWN at idx=k; PGOOD[k] is already 0.
  - Timer reloads RAMP_CYCLES-1, so rail k falls a full ramp later; lower stages then unwind normally.
- PWR_REQ=1 during RAMP_DOWN is ignored. The sequence completes to OFF, then OFF re-evaluates PWR_REQ on the next cycle.
- BROWNOUT=1 sampled in any state other than OFF or FAULT:
  - Next edge: all VDD_RAIL, PGOOD and ALL_GOOD = 0, BUSY=0, FAULT=1, state FAULT.
  - BROWNOUT in OFF has no effect.
  - BROWNOUT wins over a simultaneous PWR_REQ change or timer expiry.
- FAULT: exit to OFF only when FAULT_CLR=1 and PWR_REQ=0 are sampled together. FAULT_CLR with PWR_REQ=1 is ignored.
- RESETn assertion mid-sequence forces all outputs to 0 immediately (asynchronous), regardless of state.
- N_DOMAINS=1: RAMP_UP k=0 goes straight to ON at expiry; RAMP_DOWN k=0 goes straight to OFF.
- RAMP_CYCLES=1: each stage lasts exactly one cycle.
- Invariants, checked by assertions:
  - PGOOD[k] implies VDD_RAIL[k].
  - VDD_RAIL[k] implies VDD_RAIL[j] for all j<k.
  - BUSY, FAULT and ALL_GOOD are mutually exclusive.

Test Plan:
- Power-up, N=2, R=4: PWR_REQ 0->1 sampled at edge 0 -> VDD_RAIL=01 at edge 1; PGOOD=01 and VDD_RAIL=11 at edge 5; PGOOD=11, ALL_GOOD=1, BUSY=0 at edge 9.
- Power-down from ON, N=2, R=4: PWR_REQ=0 sampled at t -> PGOOD=01, ALL_GOOD=0 at t+1; VDD_RAIL=01, PGOOD=00 at t+5; VDD_RAIL=00, BUSY=0 at t+9.
- Abort mid-ramp, N=3, R=4: drop PWR_REQ 2 cycles into stage 1 -> rail1 low 4 cycles after sampling, then rail0 low 4 cycles later; PGOOD[1], PGOOD[2] and rail2 never rise.
- Brown-out in ON, N=2: pulse BROWNOUT for 1 cycle -> next edge all rails/PGOOD 0, FAULT=1. FAULT_CLR with PWR_REQ=1 leaves FAULT=1. FAULT_CLR with PWR_REQ=0 -> OFF, FAULT=0.
- Async reset mid RAMP_UP, N=4, R=8: assert RESETn between clock edges at stage 2 -> all outputs 0 before the next CLK edge. After release with PWR_REQ=1, the sequence restarts from domain 0.
- Corners: N=1, R=1 power-up gives VDD_RAIL=1 at edge 1 and PGOOD=ALL_GOOD=1 at edge 2. Toggling PWR_REQ 0->1 during RAMP_DOWN completes to OFF, then restarts RAMP_UP one cycle later.
